// File: rtl/spi_dev_dispatch.sv
// Routes SPI device transactions to N_EP endpoints: first byte {id, op} selects the endpoint,
// later bytes go to it as payload. Optional `SPI_DISPATCH_BCAST_EN makes id 4'hF a broadcast.
module spi_dev_dispatch #(
  parameter int N_EP  = 4,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pw_wdata,
  input  logic              pw_wcmd,
  input  logic              pw_wstb,
  input  logic              pw_end,
  output logic [7:0]        usr_miso_data,
  input  logic              usr_miso_ack,
  output logic [7:0]        ep_wdata,
  output logic [3:0]        ep_op,
  output logic [N_EP-1:0]   ep_start,
  output logic [N_EP-1:0]   ep_wstb,
  output logic [N_EP-1:0]   ep_end,
  input  logic [8*N_EP-1:0] ep_rdata,
  output logic [N_EP-1:0]   ep_rack,
  output logic [LEN_W-1:0]  xfer_len,
  output logic              xfer_done,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, DISCARD} state_t;

  state_t           state;
  logic [3:0]       sel;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_inc;
  logic             bcast;
  logic [3:0]       cmd_id;
  logic             id_ok;
  logic [N_EP-1:0]  sel_mask;
  logic [N_EP-1:0]  id_mask;

  assign cmd_id    = pw_wdata[7:4];
  assign id_ok     = int'(cmd_id) < N_EP;
  assign count_inc = (count == {LEN_W{1'b1}}) ? count : count + LEN_W'(1);

`ifndef SPI_DISPATCH_BCAST_EN
  assign bcast = 1'b0;
`endif

  // A broadcast transaction selects every endpoint at once.
  always_comb begin
    sel_mask = '0;
    id_mask  = '0;
    for (int i = 0; i < N_EP; i++) begin
      sel_mask[i] = bcast | (sel == 4'(i));
      id_mask[i]  = (cmd_id == 4'(i));
    end
  end

  // MISO returns idle-high except while a single endpoint owns the transaction.
  always_comb begin
    usr_miso_data = 8'hFF;
    ep_rack       = '0;
    if (state == DATA && !bcast) begin
      for (int i = 0; i < N_EP; i++) begin
        if (sel == 4'(i)) usr_miso_data = ep_rdata[8*i +: 8];
      end
      ep_rack = usr_miso_ack ? sel_mask : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      count     <= '0;
      ep_op     <= '0;
      ep_wdata  <= '0;
      ep_start  <= '0;
      ep_wstb   <= '0;
      ep_end    <= '0;
      xfer_len  <= '0;
      xfer_done <= 1'b0;
      err_cnt   <= '0;
`ifdef SPI_DISPATCH_BCAST_EN
      bcast     <= 1'b0;
`endif
    end else begin
      ep_start  <= '0;
      ep_wstb   <= '0;
      ep_end    <= '0;
      xfer_done <= 1'b0;
      if (pw_wstb && pw_wcmd) begin
        // A command arriving mid-transaction closes the old one in the same cycle.
        if (state == DATA) begin
          ep_end    <= sel_mask;
          xfer_len  <= count;
          xfer_done <= 1'b1;
        end
        if (id_ok) begin
          state    <= DATA;
          sel      <= cmd_id;
          ep_op    <= pw_wdata[3:0];
          ep_start <= id_mask;
          count    <= '0;
`ifdef SPI_DISPATCH_BCAST_EN
          bcast    <= 1'b0;
        end else if (cmd_id == 4'hF) begin
          state    <= DATA;
          ep_op    <= pw_wdata[3:0];
          ep_start <= '1;
          count    <= '0;
          bcast    <= 1'b1;
`endif
        end else begin
          state <= DISCARD;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef SPI_DISPATCH_BCAST_EN
          bcast <= 1'b0;
`endif
        end
      end else if (state == DATA) begin
        if (pw_wstb) begin
          ep_wdata <= pw_wdata;
          ep_wstb  <= sel_mask;
          count    <= count_inc;
        end
        if (pw_end) begin
          ep_end    <= sel_mask;
          xfer_len  <= pw_wstb ? count_inc : count;
          xfer_done <= 1'b1;
          state     <= IDLE;
        end
      end else if (state == DISCARD && pw_end) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_spi_dev_dispatch.sv
// Self-checking bench for spi_dev_dispatch (N_EP=4, LEN_W=8); honours `SPI_DISPATCH_BCAST_EN.
module tb_spi_dev_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pw_wdata = '0;
  logic        pw_wcmd = 1'b0;
  logic        pw_wstb = 1'b0;
  logic        pw_end = 1'b0;
  logic [7:0]  usr_miso_data;
  logic        usr_miso_ack = 1'b0;
  logic [7:0]  ep_wdata;
  logic [3:0]  ep_op;
  logic [3:0]  ep_start;
  logic [3:0]  ep_wstb;
  logic [3:0]  ep_end;
  logic [31:0] ep_rdata = {8'hD4, 8'hC3, 8'h3C, 8'hA1};
  logic [3:0]  ep_rack;
  logic [7:0]  xfer_len;
  logic        xfer_done;
  logic [7:0]  err_cnt;

  spi_dev_dispatch #(.N_EP(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb), .pw_end(pw_end),
    .usr_miso_data(usr_miso_data), .usr_miso_ack(usr_miso_ack),
    .ep_wdata(ep_wdata), .ep_op(ep_op), .ep_start(ep_start), .ep_wstb(ep_wstb),
    .ep_end(ep_end), .ep_rdata(ep_rdata), .ep_rack(ep_rack),
    .xfer_len(xfer_len), .xfer_done(xfer_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_err  = 0;
  logic [7:0]  sh_wdata = '0;
  logic [7:0]  sh_len   = '0;
  // {ep_start, ep_wstb, ep_end, xfer_done, ep_wdata, xfer_len}
  logic [28:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One input cycle; pushes what the DUT must show after the next edge.
  task automatic step(input logic cmd, input logic stb, input logic en, input logic [7:0] d,
                      input logic [3:0] es, input logic [3:0] ew, input logic [3:0] ee,
                      input int elen);
    @(negedge clk);
    pw_wcmd = cmd; pw_wstb = stb; pw_end = en; pw_wdata = d;
    if (ew != 4'b0) sh_wdata = d;
    if (elen >= 0) sh_len = elen[7:0];
    exp_q.push_back({es, ew, ee, (elen >= 0), sh_wdata, sh_len});
    @(posedge clk);
    #2;
    pw_wcmd = 1'b0; pw_wstb = 1'b0; pw_end = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'b0, 4'b0, 4'b0, -1);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("xfer", {ep_start, ep_wstb, ep_end, xfer_done, ep_wdata, xfer_len}, exp_q.pop_front());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outs", {ep_start, ep_wstb, ep_end, ep_rack, xfer_done}, 17'h0);
    check("rst_err", err_cnt, 8'd0);
    check("rst_len", xfer_len, 8'd0);
    check("rst_miso", usr_miso_data, 8'hFF);
    rst = 1'b0;

    // Reset in the middle of a transaction
    step(1'b1, 1'b1, 1'b0, 8'h70, 4'b0, 4'b0, 4'b0, -1);
    check("err_first", err_cnt, 8'd1);
    step(1'b1, 1'b1, 1'b0, 8'h12, 4'b0010, 4'b0, 4'b0, -1);
    step(1'b0, 1'b1, 1'b0, 8'h11, 4'b0, 4'b0010, 4'b0, -1);
    step(1'b0, 1'b1, 1'b0, 8'h22, 4'b0, 4'b0010, 4'b0, -1);
    #1 rst = 1'b1;
    #1;
    check("arst_outs", {ep_start, ep_wstb, ep_end, ep_rack, xfer_done}, 17'h0);
    check("arst_data", {ep_wdata, ep_op, xfer_len, err_cnt}, 28'h0);
    check("arst_miso", usr_miso_data, 8'hFF);
    sh_wdata = '0; sh_len = '0;
    @(negedge clk) rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 8'h12, 4'b0010, 4'b0, 4'b0, -1);
    check("op_12", ep_op, 4'd2);
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b0010, 0);

    // Basic write transaction to endpoint 2
    step(1'b1, 1'b1, 1'b0, 8'h23, 4'b0100, 4'b0, 4'b0, -1);
    check("op_23", ep_op, 4'd3);
    step(1'b0, 1'b1, 1'b0, 8'hAA, 4'b0, 4'b0100, 4'b0, -1);
    step(1'b0, 1'b1, 1'b0, 8'h55, 4'b0, 4'b0100, 4'b0, -1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b0100, 2);
    idle();
    // Payload byte while idle is dropped
    step(1'b0, 1'b1, 1'b0, 8'h99, 4'b0, 4'b0, 4'b0, -1);

    // MISO read path on endpoint 1
    check("miso_idle", usr_miso_data, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 8'h10, 4'b0010, 4'b0, 4'b0, -1);
    check("miso_ep1", usr_miso_data, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) usr_miso_ack = 1'b1;
      #1 check("rack_ep1", ep_rack, 4'b0010);
      #1 usr_miso_ack = 1'b0;
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b0010, 0);
    @(negedge clk) usr_miso_ack = 1'b1;
    #1 check("rack_idle", ep_rack, 4'b0);
    #1 usr_miso_ack = 1'b0;

    // Reserved id 4'hF
`ifdef SPI_DISPATCH_BCAST_EN
    step(1'b1, 1'b1, 1'b0, 8'hF2, 4'b1111, 4'b0, 4'b0, -1);
    check("bc_op", ep_op, 4'd2);
    check("bc_miso", usr_miso_data, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 8'h5A, 4'b0, 4'b1111, 4'b0, -1);
    @(negedge clk) usr_miso_ack = 1'b1;
    #1 check("bc_rack", ep_rack, 4'b0);
    #1 usr_miso_ack = 1'b0;
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b1111, 1);
`else
    step(1'b1, 1'b1, 1'b0, 8'hF2, 4'b0, 4'b0, 4'b0, -1);
    step(1'b0, 1'b1, 1'b0, 8'h5A, 4'b0, 4'b0, 4'b0, -1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b0, -1);
    exp_err++;
`endif
    check("err_f", err_cnt, 8'(exp_err));

    // Invalid id with payload: discarded, counted once
    step(1'b1, 1'b1, 1'b0, 8'h70, 4'b0, 4'b0, 4'b0, -1);
    exp_err++;
    check("disc_miso", usr_miso_data, 8'hFF);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 4'b0, 4'b0, 4'b0, -1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b0, -1);
    check("err_70", err_cnt, 8'(exp_err));

    // Byte coincident with pw_end on endpoint 0
    step(1'b1, 1'b1, 1'b0, 8'h0A, 4'b0001, 4'b0, 4'b0, -1);
    step(1'b0, 1'b1, 1'b0, 8'h01, 4'b0, 4'b0001, 4'b0, -1);
    step(1'b0, 1'b1, 1'b1, 8'h02, 4'b0, 4'b0001, 4'b0001, 2);

    // Missed pw_end: new command closes old transaction
    step(1'b1, 1'b1, 1'b0, 8'h05, 4'b0001, 4'b0, 4'b0, -1);
    step(1'b0, 1'b1, 1'b0, 8'h77, 4'b0, 4'b0001, 4'b0, -1);
    step(1'b1, 1'b1, 1'b0, 8'h31, 4'b1000, 4'b0, 4'b0001, 1);
    check("op_31", ep_op, 4'd1);
    step(1'b0, 1'b1, 1'b0, 8'h66, 4'b0, 4'b1000, 4'b0, -1);
    step(1'b1, 1'b1, 1'b0, 8'h3F, 4'b1000, 4'b0, 4'b1000, 1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b1000, 0);

    // Payload length saturates at 255
    step(1'b1, 1'b1, 1'b0, 8'h20, 4'b0100, 4'b0, 4'b0, -1);
    for (int k = 0; k < 257; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      step(1'b0, 1'b1, 1'b0, b, 4'b0, 4'b0100, 4'b0, -1);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b0100, 255);

    // Error counter saturates at 255
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 1'b1, 1'b0, 8'h70, 4'b0, 4'b0, 4'b0, -1);
      step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b0, -1);
    end
    check("err_sat", err_cnt, 8'd255);
    step(1'b1, 1'b1, 1'b0, 8'h12, 4'b0010, 4'b0, 4'b0, -1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'b0, 4'b0, 4'b0010, 0);

    @(posedge clk);
    #3;
    check("drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_dev_dispatch.md
Name: spi_dev_dispatch

Overview:
Sequencer between the SPI device protocol wrapper and up to N_EP register/stream endpoints. Decodes the first byte of each chip-select transaction as {endpoint id, opcode} and routes payload bytes to the selected endpoint. Muxes that endpoint's read data back onto the MISO byte stream and forwards MISO acks. Emits per-endpoint start/end pulses, tracks payload length and counts malformed transactions.

Parameters:
N_EP, 4, number of endpoints (1..15); id 4'hF is reserved.
LEN_W, 8, width of payload byte counter xfer_len.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
pw_wdata  in  8  received byte from protocol wrapper
pw_wcmd  in  1  high when the current pw_wstb byte is the first of the transaction
pw_wstb  in  1  one-cycle strobe: pw_wdata valid
pw_end  in  1  one-cycle pulse: chip select released
usr_miso_data  out  8  next byte to shift out on MISO
usr_miso_ack  in  1  one-cycle pulse: usr_miso_data consumed
ep_wdata  out  8  registered payload byte, shared by all endpoints
ep_op  out  4  opcode of the current transaction, shared
ep_start  out  N_EP  one-hot start pulse
ep_wstb  out  N_EP  one-hot payload write strobe
ep_end  out  N_EP  one-hot end-of-transaction pulse
ep_rdata  in  8*N_EP  per-endpoint read data; endpoint i is at [8i+7:8i]
ep_rack  out  N_EP  one-hot read acknowledge
xfer_len  out  LEN_W  payload length of the last completed transaction
xfer_done  out  1  one-cycle pulse when xfer_len updates
err_cnt  out  8  count of invalid-id transactions, saturating

Behaviour:
- Reset (async): state IDLE, sel=0, ep_op=0, ep_wdata=0, all one-hot outputs 0, xfer_len=0, xfer_done=0, err_cnt=0, internal byte count=0.
- States: IDLE, DATA, DISCARD.
- Command decode: pw_wstb & pw_wcmd in any state. id=pw_wdata[7:4], op=pw_wdata[3:0].
  - id<N_EP: next cycle sel=id, ep_op=op, ep_start[id]=1 for one cycle; state DATA; count=0.
  - Otherwise: state DISCARD; err_cnt+1, saturating at 255; no ep_start.
- Payload: pw_wstb & ~pw_wcmd in DATA. Next cycle ep_wdata=pw_wdata, ep_wstb[sel]=1; count+1, saturating at 2^LEN_W-1. In IDLE and DISCARD the byte is dropped silently.
- Latency: pw_wstb to ep_wstb/ep_start is exactly 1 cycle. Outputs are registered.
- pw_end:
  - In DATA: next cycle ep_end[sel]=1, xfer_len=count, xfer_done=1; state IDLE.
  - In DISCARD: state IDLE; no pulses.
  - In IDLE: ignored.
- Same-cycle pw_wstb (payload) and pw_end in DATA: the byte is included in count and in xfer_len. ep_wstb and ep_end fire in the same cycle.
- pw_wcmd while in DATA (pw_end was missed): the old transaction is closed. ep_end[old sel], xfer_done and xfer_len fire in the same cycle as ep_start[new id]. A new id equal to the old id is allowed; that bit of ep_end and ep_start are both 1 in that cycle.
- MISO path (combinational mux):
  - usr_miso_data = ep_rdata[sel] in DATA, else 8'hFF.
  - ep_rack[sel] = usr_miso_ack when in DATA, else 0.
  - The byte shifted during the command byte is therefore 8'hFF.
- Only one bit of ep_start, ep_wstb, ep_end or ep_rack is set at a time. The sole exception is the overlap case above.

Optional Feature:
SPI_DISPATCH_BCAST_EN
- Defined: id 4'hF is a broadcast.
  - State DATA with a broadcast flag; ep_start, ep_wstb and ep_end are driven on all N_EP bits.
  - usr_miso_data=8'hFF; ep_rack stays 0.
  - Not counted as an error.
- Undefined: id 4'hF is invalid, handled as DISCARD with an err_cnt increment.

Test Plan:
- Reset mid-DATA (assert rst after 2 payload bytes) -> all outputs 0 immediately, err_cnt=0; the next command 8'h12 decodes normally.
- Command 8'h23, payload 8'hAA, 8'h55, then pw_end -> ep_start=4'b0100 and ep_op=3; ep_wstb[2] twice with ep_wdata AA then 55; ep_end[2]; xfer_len=2; xfer_done one pulse.
- ep_rdata[1]=8'h3C, command 8'h10, 3 usr_miso_ack pulses -> usr_miso_data=8'hFF before decode, 8'h3C after; ep_rack=4'b0010 on each ack.
- Command 8'h70 with N_EP=4, 5 payload bytes, pw_end -> no ep_* activity; err_cnt 0->1; 256 such transactions -> err_cnt holds at 255.
- Payload pw_wstb coincident with pw_end on endpoint 0 after 1 prior byte -> ep_wstb[0] and ep_end[0] in the same cycle; xfer_len=2.
- Command 8'h05, then command 8'h31 with no pw_end between -> ep_end[0], ep_start[3] and xfer_done in one cycle; ep_op=1. Under SPI_DISPATCH_BCAST_EN, command 8'hF2 plus 1 byte -> ep_wstb=4'b1111.
